// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a per-register busy scoreboard.
// Two combinational read ports, one synchronous write port, one reservation
// port. A reservation marks a register busy until it is written back; a
// reservation of an already-busy register (without a same-cycle write to it)
// raises a one-cycle rsv_err pulse.
// Optional feature: define REGFILE_BYPASS_EN to forward the same-cycle write
// data (and the busy clear) onto the read ports.
module reg_file_sb #(
  parameter int unsigned WIDTH    = 32'd16,
  parameter int unsigned ADDR_W   = 32'd2,
  parameter int unsigned ZERO_REG = 32'd0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       rd_addr1,
  input  logic [ADDR_W-1:0]       rd_addr2,
  output logic [WIDTH-1:0]        rd_data1,
  output logic [WIDTH-1:0]        rd_data2,
  output logic                    rd_busy1,
  output logic                    rd_busy2,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [(2**ADDR_W)-1:0]  busy_vec,
  output logic                    rsv_err
);

  localparam int unsigned DEPTH = 32'd2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic             r_rsv_err;

  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_rsv_err_nxt;
  logic [WIDTH:0]   w_rd1;
  logic [WIDTH:0]   w_rd2;

  // True when addr is the hardwired zero register (only with ZERO_REG set).
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 32'd0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Resolve one read port: returns {busy, data}, independent of the other port.
  function automatic logic [WIDTH:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    logic             busy;
    data = r_mem[addr];
    busy = r_busy[addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (wr_addr == addr)) begin
      data = wr_data;
      // A same-cycle reservation of this register keeps its current busy bit.
      if (rsv_en && (rsv_addr == addr)) begin
        busy = r_busy[addr];
      end else begin
        busy = 1'b0;
      end
    end else begin
      data = r_mem[addr];
    end
`endif
    if (is_zero_reg(addr)) begin
      data = {WIDTH{1'b0}};
      busy = 1'b0;
    end else begin
      busy = busy;
    end
    return {busy, data};
  endfunction

  assign w_wr_ok  = wr_en  & ~is_zero_reg(wr_addr);
  assign w_rsv_ok = rsv_en & ~is_zero_reg(rsv_addr);

  // Store write data; reset clears the whole array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Next busy bits: reservation sets, write clears, reservation wins a tie.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rsv_ok && (rsv_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // WAW: reserving a busy register that is not being written this cycle.
  assign w_rsv_err_nxt = w_rsv_ok & r_busy[rsv_addr] & ~(wr_en & (wr_addr == rsv_addr));

  // Busy scoreboard and error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= {DEPTH{1'b0}};
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_rsv_err <= w_rsv_err_nxt;
    end
  end

  // Read port 1 resolution.
  always_comb begin
    w_rd1 = read_port(rd_addr1);
  end

  // Read port 2 resolution.
  always_comb begin
    w_rd2 = read_port(rd_addr2);
  end

  assign rd_data1 = w_rd1[WIDTH-1:0];
  assign rd_busy1 = w_rd1[WIDTH];
  assign rd_data2 = w_rd2[WIDTH-1:0];
  assign rd_busy2 = w_rd2[WIDTH];
  assign busy_vec = r_busy;
  assign rsv_err  = r_rsv_err;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: a table of single-cycle vectors checked through
// an expectation queue, plus hand-written sequences for reset, bypass and the
// hardwired-zero configuration (second instance).
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;

  // Default instance: WIDTH 16, ADDR_W 2, ZERO_REG 0
  logic [1:0]  rd_addr1, rd_addr2, rsv_addr, wr_addr;
  logic [15:0] rd_data1, rd_data2, wr_data;
  logic        rd_busy1, rd_busy2, rsv_en, wr_en, rsv_err;
  logic [3:0]  busy_vec;

  // Zero-register instance: WIDTH 32, ADDR_W 3, ZERO_REG 1
  logic [2:0]  z_rd_addr1, z_rd_addr2, z_rsv_addr, z_wr_addr;
  logic [31:0] z_rd_data1, z_rd_data2, z_wr_data;
  logic        z_rd_busy1, z_rd_busy2, z_rsv_en, z_wr_en, z_rsv_err;
  logic [7:0]  z_busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_sb u_dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_vec(busy_vec), .rsv_err(rsv_err)
  );

  reg_file_sb #(.WIDTH(32'd32), .ADDR_W(32'd3), .ZERO_REG(32'd1)) u_z (
    .clk(clk), .reset_n(reset_n),
    .rd_addr1(z_rd_addr1), .rd_addr2(z_rd_addr2),
    .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
    .rd_busy1(z_rd_busy1), .rd_busy2(z_rd_busy2),
    .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .busy_vec(z_busy_vec), .rsv_err(z_rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ra1;
    logic [1:0]  ra2;
    logic        rsv_en;
    logic [1:0]  rsv_addr;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] e_d1;
    logic        e_b1;
    logic [15:0] e_d2;
    logic        e_b2;
    logic [3:0]  e_bv;
    logic        e_err;
  } vec_t;

  vec_t vt[13];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [1:0] ra1, input logic [1:0] ra2,
                              input logic re, input logic [1:0] ra,
                              input logic we, input logic [1:0] wa, input logic [15:0] wd,
                              input logic [15:0] d1, input logic b1,
                              input logic [15:0] d2, input logic b2,
                              input logic [3:0] bv, input logic err);
    vec_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.rsv_en = re; v.rsv_addr = ra;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.e_d1 = d1; v.e_b1 = b1; v.e_d2 = d2; v.e_b2 = b2;
    v.e_bv = bv; v.e_err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rsv_en = 1'b0; wr_en = 1'b0;
    z_rsv_en = 1'b0; z_wr_en = 1'b0;
  endtask

  // Wait through the next rising edge, drop the enables, let reads settle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  initial begin
    vec_t e;
    reset_n = 1'b0;
    rd_addr1 = 2'd0; rd_addr2 = 2'd0; rsv_addr = 2'd0; wr_addr = 2'd0; wr_data = 16'h0000;
    z_rd_addr1 = 3'd0; z_rd_addr2 = 3'd0; z_rsv_addr = 3'd0; z_wr_addr = 3'd0;
    z_wr_data = 32'h0;
    idle_inputs();

    //            ra1   ra2   rsv       wr                  d1       b1    d2       b2    bv       err
    vt[0]  = mk(2'd2, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0);
    vt[1]  = mk(2'd3, 2'd2, 1'b1, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 4'b1000, 1'b0);
    vt[2]  = mk(2'd3, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1000, 1'b0);
    vt[3]  = mk(2'd3, 2'd2, 1'b0, 2'd0, 1'b1, 2'd3, 16'h1234, 16'h1234, 1'b0, 16'hBEEF, 1'b0, 4'b0000, 1'b0);
    vt[4]  = mk(2'd2, 2'd3, 1'b1, 2'd2, 1'b1, 2'd2, 16'h0F0F, 16'h0F0F, 1'b1, 16'h1234, 1'b0, 4'b0100, 1'b0);
    vt[5]  = mk(2'd1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0F0F, 1'b1, 4'b0110, 1'b0);
    vt[6]  = mk(2'd1, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'b0110, 1'b1);
    vt[7]  = mk(2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b0110, 1'b0);
    vt[8]  = mk(2'd2, 2'd1, 1'b1, 2'd2, 1'b1, 2'd2, 16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 4'b0110, 1'b0);
    vt[9]  = mk(2'd1, 2'd0, 1'b1, 2'd0, 1'b1, 2'd1, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b1, 4'b0101, 1'b0);
    vt[10] = mk(2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 16'h0001, 16'h0001, 1'b0, 16'h0001, 1'b0, 4'b0100, 1'b0);
    vt[11] = mk(2'd2, 2'd3, 1'b1, 2'd2, 1'b0, 2'd0, 16'h0000, 16'h5555, 1'b1, 16'h1234, 1'b0, 4'b0100, 1'b1);
    vt[12] = mk(2'd2, 2'd2, 1'b0, 2'd0, 1'b1, 2'd2, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 4'b0000, 1'b0);

    // Reset state without any clock edge
    #3;
    check("reset_busy_vec", 32'(busy_vec), 32'h0);
    check("reset_rsv_err", 32'(rsv_err), 32'h0);
    check("reset_rd_data1", 32'(rd_data1), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors through the expectation queue
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rd_addr1 = vt[i].ra1; rd_addr2 = vt[i].ra2;
      rsv_en = vt[i].rsv_en; rsv_addr = vt[i].rsv_addr;
      wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      exp_q.push_back(vt[i]);
      step();
      e = exp_q.pop_front();
      check($sformatf("v%0d_rd_data1", i), 32'(rd_data1), 32'(e.e_d1));
      check($sformatf("v%0d_rd_busy1", i), 32'(rd_busy1), 32'(e.e_b1));
      check($sformatf("v%0d_rd_data2", i), 32'(rd_data2), 32'(e.e_d2));
      check($sformatf("v%0d_rd_busy2", i), 32'(rd_busy2), 32'(e.e_b2));
      check($sformatf("v%0d_busy_vec", i), 32'(busy_vec), 32'(e.e_bv));
      check($sformatf("v%0d_rsv_err", i), 32'(rsv_err), 32'(e.e_err));
    end

    // Reset mid-operation: data, reservation and a live error pulse all cleared
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
    rsv_en = 1'b1; rsv_addr = 2'd1;
    rd_addr1 = 2'd2;
    step();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 2'd1;
    step();
    check("pre_reset_err", 32'(rsv_err), 32'h1);
    check("pre_reset_data", 32'(rd_data1), 32'hBEEF);
    reset_n = 1'b0;
    #1;
    check("mid_reset_data", 32'(rd_data1), 32'h0);
    check("mid_reset_busy_vec", 32'(busy_vec), 32'h0);
    check("mid_reset_err", 32'(rsv_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Same-cycle forwarding on both ports
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'hA5A5;
    rd_addr1 = 2'd1; rd_addr2 = 2'd1;
    #1;
    check("byp_rd_data1", 32'(rd_data1), BYP ? 32'hA5A5 : 32'h0);
    check("byp_rd_data2", 32'(rd_data2), BYP ? 32'hA5A5 : 32'h0);
    step();
    check("post_byp_rd_data1", 32'(rd_data1), 32'hA5A5);
    check("post_byp_rd_data2", 32'(rd_data2), 32'hA5A5);

    // Reservation is not forwarded in the same cycle
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 2'd3; rd_addr1 = 2'd3; rd_addr2 = 2'd3;
    #1;
    check("rsv_not_fwd", 32'(rd_busy1), 32'h0);
    step();
    check("rsv_visible", 32'(rd_busy1), 32'h1);

    // Write plus reservation to a busy register: forwarded data, busy held
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h7777;
    rsv_en = 1'b1; rsv_addr = 2'd3;
    #1;
    check("byp_rsv_data", 32'(rd_data1), BYP ? 32'h7777 : 32'h0);
    check("byp_rsv_busy", 32'(rd_busy1), 32'h1);
    step();
    check("byp_rsv_bv", 32'(busy_vec), 32'h8);

    // Write alone to a busy register: forwarded busy clear, busy_vec unaffected
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h1111;
    #1;
    check("byp_clr_data", 32'(rd_data2), BYP ? 32'h1111 : 32'h7777);
    check("byp_clr_busy", 32'(rd_busy2), BYP ? 32'h0 : 32'h1);
    check("byp_clr_bv_raw", 32'(busy_vec), 32'h8);
    step();
    check("post_clr_data", 32'(rd_data2), 32'h1111);
    check("post_clr_busy", 32'(rd_busy2), 32'h0);

    // Hardwired zero register instance
    @(negedge clk);
    z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 32'hFFFFFFFF;
    z_rsv_en = 1'b1; z_rsv_addr = 3'd0; z_rd_addr1 = 3'd0; z_rd_addr2 = 3'd7;
    #1;
    check("z_r0_same_cycle", z_rd_data1, 32'h0);
    step();
    check("z_r0_data", z_rd_data1, 32'h0);
    check("z_r0_busy", 32'(z_rd_busy1), 32'h0);
    check("z_busy_vec", 32'(z_busy_vec), 32'h0);
    check("z_err", 32'(z_rsv_err), 32'h0);
    @(negedge clk);
    z_rsv_en = 1'b1; z_rsv_addr = 3'd0;
    step();
    check("z_r0_rerserve_err", 32'(z_rsv_err), 32'h0);
    @(negedge clk);
    z_wr_en = 1'b1; z_wr_addr = 3'd7; z_wr_data = 32'hFFFFFFFF;
    step();
    check("z_r7_data", z_rd_data2, 32'hFFFFFFFF);
    @(negedge clk);
    z_rsv_en = 1'b1; z_rsv_addr = 3'd7;
    step();
    @(negedge clk);
    z_rsv_en = 1'b1; z_rsv_addr = 3'd7;
    step();
    check("z_r7_waw_err", 32'(z_rsv_err), 32'h1);
    check("z_r7_busy_vec", 32'(z_busy_vec), 32'h80);
    check("z_r7_busy", 32'(z_rd_busy2), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-ported general-purpose register file with a per-register busy scoreboard, used by the CPU datapath in place of the fixed 4×16-bit register file. It provides two combinational read ports and one synchronous write port. Per-register reservation bits mark registers awaiting a multi-cycle writeback, so decode can stall on RAW hazards. Reset is asynchronous and clears all data and reservations.

## Interface
- WIDTH, 16, data word width in bits
- ADDR_W, 2, register address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1 register 0 is hardwired to zero: writes ignored, never busy

- clk  in  1  rising-edge clock; the block has one clock
- reset_n  in  1  reset, asynchronous, active-low
- rd_addr1, rd_addr2  in  ADDR_W  read port addresses
- rd_data1, rd_data2  out  WIDTH  read data, combinational
- rd_busy1, rd_busy2  out  1  addressed register has a pending reservation
- rsv_en  in  1  reserve register rsv_addr (mark busy)
- rsv_addr  in  ADDR_W  register to reserve
- wr_en  in  1  write wr_data to wr_addr; clears its busy bit
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- busy_vec  out  DEPTH  busy bit of every register, bit i = register i
- rsv_err  out  1  registered one-cycle pulse: reservation of an already-busy register (WAW)

## Operation
- State: DEPTH×WIDTH data array, DEPTH busy bits, rsv_err flop.
- Write: on posedge clk with wr_en=1, reg[wr_addr] <= wr_data. The write is accepted whether or not the register is busy.
- Busy update per register i at each posedge:
  - set if rsv_en and rsv_addr==i;
  - else cleared if wr_en and wr_addr==i;
  - else held.
  - Reservation wins over a same-cycle write to the same register: data is written and busy stays 1.
- rsv_err <= rsv_en & busy[rsv_addr] & ~(wr_en & wr_addr==rsv_addr). It is 0 in every cycle without such a reservation.
- Reads are combinational: rd_dataN = reg[rd_addrN], rd_busyN = busy[rd_addrN], subject to bypass (see Configuration).
- ZERO_REG=1:
  - reads of address 0 return 0 and rd_busy 0;
  - writes and reservations to address 0 have no effect;
  - busy_vec[0]=0;
  - reserving address 0 never raises rsv_err.
- Both read ports may address the same register, the write address, or the reservation address in the same cycle. Each port resolves independently.

## Timing
- Reset (reset_n=0, immediate, no clock needed): all registers 0, all busy bits 0, busy_vec 0, rsv_err 0. rd_data/rd_busy then reflect the cleared state.
- Reset asserted mid-operation discards pending reservations and data. The first posedge after deassertion operates normally.
- Write latency: 1 cycle. The value is stored at the posedge where wr_en=1 and visible on reads from then on, or the same cycle with bypass.
- Reservation latency: busy visible after the posedge where rsv_en=1. It is not forwarded same-cycle.
- Busy clear: busy is 0 after the writing posedge, or the same cycle on the read port with bypass.
- rsv_err asserts for exactly the one cycle following the offending edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is active. If wr_en=1 and wr_addr==rd_addrN (and not the hardwired zero register), then in the same cycle:
  - rd_dataN = wr_data;
  - rd_busyN = 0, unless rsv_en=1 with rsv_addr==rd_addrN, in which case rd_busyN = busy[rd_addrN] unchanged.
- REGFILE_BYPASS_EN undefined: reads return array contents and current busy bits only. Written data appears the cycle after the write edge.
- busy_vec never includes bypass effects in either configuration.

## Test plan
- Reset: write 0xBEEF to r2, reserve r1, then pulse reset_n low between edges -> rd_data(r2)=0x0000, busy_vec=0 immediately, rsv_err=0.
- Reserve/write: rsv_en r3 at edge 1 -> rd_busy=1 on r3 after edge 1. wr_en r3=0x1234 at edge 3 -> after edge 3, rd_data=0x1234, rd_busy=0.
- Bypass: wr_en r1=0xA5A5 with rd_addr1=rd_addr2=1, r1 previously 0x0000 -> same cycle 0xA5A5 on both ports with REGFILE_BYPASS_EN, 0x0000 without. Both configurations read 0xA5A5 after the edge.
- Simultaneous: rsv_en r2 and wr_en r2=0x0F0F in one cycle, r2 idle -> after edge r2=0x0F0F, busy_vec[2]=1, rsv_err=0.
- WAW: reserve r1, then reserve r1 again next cycle with no write -> rsv_err=1 for exactly one cycle, busy_vec[1] stays 1.
- ZERO_REG=1, ADDR_W=3, WIDTH=32: wr_en r0=0xFFFFFFFF, rsv_en r0 -> rd_data(r0)=0, busy_vec=8'h00, rsv_err=0. Write r7=0xFFFFFFFF -> reads back 0xFFFFFFFF.
